// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 access sequencer: op codes, CP0 register
// addresses, bit positions and the sequencer state encoding.
package cp0_pkg;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_MFC0 = 3'd1;
   localparam logic [2:0] OP_MTC0 = 3'd2;
   localparam logic [2:0] OP_ERET = 3'd3;
   localparam logic [2:0] OP_EXC  = 3'd4;

   localparam logic [7:0] CP0_STATUS_ADDR = 8'd96;
   localparam logic [7:0] CP0_CAUSE_ADDR  = 8'd104;
   localparam logic [7:0] CP0_EPC_ADDR    = 8'd112;

   localparam int STATUS_EXL   = 1;
   localparam int CAUSE_BD     = 31;
   localparam int CAUSE_EXC_HI = 6;
   localparam int CAUSE_EXC_LO = 2;

   localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_MFC      = 4'd1,
      ST_MTC      = 4'd2,
      ST_EX_ST    = 4'd3,
      ST_EX_EPC   = 4'd4,
      ST_EX_CAUSE = 4'd5,
      ST_ER_EPC   = 4'd6,
      ST_ER_ST    = 4'd7,
      ST_FIN      = 4'd8
   } cp0_state_e;

endpackage

// File: rtl/cp0_access_ctrl.sv
// MEM-stage initiator for the CP0 register file: turns one MFC0/MTC0/ERET/
// exception request at a time into single-port CP0 accesses plus a response.
module cp0_access_ctrl
   import cp0_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT,
   parameter logic [7:0]  STATUS_ADDR = CP0_STATUS_ADDR,
   parameter logic [7:0]  CAUSE_ADDR  = CP0_CAUSE_ADDR,
   parameter logic [7:0]  EPC_ADDR    = CP0_EPC_ADDR
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [7:0]  req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   input  logic        req_bd,
   input  logic [4:0]  req_exccode,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy,
   output logic        cp0_wen,
   output logic [7:0]  cp0_addr,
   output logic [31:0] cp0_wdata,
   input  logic [31:0] cp0_rdata,
   output logic [3:0]  dbg_state
);

   // Handshake: a request transfers on the clk edge where req_valid && req_ready;
   // req_ready is high only in IDLE, and every req_* field is captured on that edge.

   cp0_state_e  state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] pc_q, pc_d;
   logic        bd_q, bd_d;
   logic [4:0]  exccode_q, exccode_d;
   logic        old_exl_q, old_exl_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        wen_raw;
   logic [31:0] cause_w;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         op_q          <= OP_NOP;
         addr_q        <= '0;
         wdata_q       <= '0;
         pc_q          <= '0;
         bd_q          <= 1'b0;
         exccode_q     <= '0;
         old_exl_q     <= 1'b0;
         epc_q         <= '0;
         resp_data_q   <= '0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         pc_q          <= pc_d;
         bd_q          <= bd_d;
         exccode_q     <= exccode_d;
         old_exl_q     <= old_exl_d;
         epc_q         <= epc_d;
         resp_data_q   <= resp_data_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      pc_d          = pc_q;
      bd_d          = bd_q;
      exccode_d     = exccode_q;
      old_exl_d     = old_exl_q;
      epc_d         = epc_q;
      resp_data_d   = resp_data_q;
      redirect_pc_d = redirect_pc_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               op_d      = req_op;
               addr_d    = req_addr;
               wdata_d   = req_wdata;
               pc_d      = req_pc;
               bd_d      = req_bd;
               exccode_d = req_exccode;
               case (req_op)
                  OP_MFC0: state_d = ST_MFC;
                  OP_MTC0: state_d = ST_MTC;
                  OP_ERET: state_d = ST_ER_EPC;
                  OP_EXC:  state_d = ST_EX_ST;
                  default: state_d = ST_IDLE;
               endcase
            end
         end
         ST_MFC: begin
            resp_data_d = cp0_rdata;
            state_d     = ST_FIN;
         end
         ST_MTC:    state_d = ST_FIN;
         ST_EX_ST: begin
            // EXL as it was before this exception decides EPC/BD updates.
            old_exl_d = cp0_rdata[STATUS_EXL];
            state_d   = ST_EX_EPC;
         end
         ST_EX_EPC: state_d = ST_EX_CAUSE;
         ST_EX_CAUSE: begin
            redirect_pc_d = EXC_VECTOR;
            state_d       = ST_FIN;
         end
         ST_ER_EPC: begin
            epc_d   = cp0_rdata;
            state_d = ST_ER_ST;
         end
         ST_ER_ST: begin
            redirect_pc_d = epc_q;
            state_d       = ST_FIN;
         end
         ST_FIN:    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cause_w = cp0_rdata;
      cause_w[CAUSE_EXC_HI:CAUSE_EXC_LO] = exccode_q;
      if (!old_exl_q) begin
         cause_w[CAUSE_BD] = bd_q;
      end
   end

   always_comb begin
      req_ready      = (state_q == ST_IDLE);
      busy           = (state_q != ST_IDLE);
      resp_valid     = (state_q == ST_FIN) && (op_q == OP_MFC0);
      redirect_valid = (state_q == ST_FIN) && ((op_q == OP_EXC) || (op_q == OP_ERET));
      resp_data      = resp_data_q;
      redirect_pc    = redirect_pc_q;
      dbg_state      = state_q;
      wen_raw        = 1'b0;
      cp0_addr       = '0;
      cp0_wdata      = '0;
      case (state_q)
         ST_MFC: cp0_addr = addr_q;
         ST_MTC: begin
            wen_raw   = 1'b1;
            cp0_addr  = addr_q;
            cp0_wdata = wdata_q;
         end
         ST_EX_ST: begin
            wen_raw   = 1'b1;
            cp0_addr  = STATUS_ADDR;
            cp0_wdata = cp0_rdata | 32'h0000_0002;
         end
         ST_EX_EPC: begin
            wen_raw   = !old_exl_q;
            cp0_addr  = EPC_ADDR;
            cp0_wdata = bd_q ? (pc_q - 32'd4) : pc_q;
         end
         ST_EX_CAUSE: begin
            wen_raw   = 1'b1;
            cp0_addr  = CAUSE_ADDR;
            cp0_wdata = cause_w;
         end
         ST_ER_EPC: cp0_addr = EPC_ADDR;
         ST_ER_ST: begin
            wen_raw   = 1'b1;
            cp0_addr  = STATUS_ADDR;
            cp0_wdata = cp0_rdata & ~32'h0000_0002;
         end
         default: begin
            wen_raw = 1'b0;
         end
      endcase
      // A reset landing mid-sequence must not commit the write of the aborted step.
      cp0_wen = wen_raw & resetn;
   end

endmodule

// File: tb/tb_cp0_access_ctrl.sv
// Directed bench for cp0_access_ctrl against a simple behavioural CP0
// register file (write on clk when cp0_wen, combinational read).
module tb_cp0_access_ctrl;
   import cp0_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = '0;
   logic [7:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [31:0] req_pc = '0;
   logic        req_bd = 1'b0;
   logic [4:0]  req_exccode = '0;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        busy;
   logic        cp0_wen;
   logic [7:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic [31:0] cp0_rdata;
   logic [3:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   logic [31:0] regs [256];

   cp0_access_ctrl dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
      .req_bd(req_bd), .req_exccode(req_exccode),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .busy(busy), .cp0_wen(cp0_wen), .cp0_addr(cp0_addr),
      .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .dbg_state(dbg_state)
   );

   // clock / reset-independent CP0 register file model
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cp0_wen) regs[cp0_addr] <= cp0_wdata;
   end
   assign cp0_rdata = regs[cp0_addr];

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] pc;
      logic        bd;
      logic [4:0]  exccode;
      int          resp_k;
      logic [31:0] resp_d;
      int          redir_k;
      logic [31:0] redir_pc;
      int          wen_n;
      int          busy_n;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t base(input string name, input logic [2:0] op);
      vec_t v;
      v.name = name; v.op = op; v.addr = '0; v.wdata = '0; v.pc = '0;
      v.bd = 1'b0; v.exccode = '0; v.resp_k = 0; v.resp_d = '0;
      v.redir_k = 0; v.redir_pc = '0; v.wen_n = 0; v.busy_n = 0;
      return v;
   endfunction

   function automatic vec_t mtc(input string name, input logic [7:0] a, input logic [31:0] d);
      vec_t v = base(name, OP_MTC0);
      v.addr = a; v.wdata = d; v.wen_n = 1; v.busy_n = 2;
      return v;
   endfunction

   function automatic vec_t mfc(input string name, input logic [7:0] a, input logic [31:0] exp);
      vec_t v = base(name, OP_MFC0);
      v.addr = a; v.resp_k = 2; v.resp_d = exp; v.busy_n = 2;
      return v;
   endfunction

   function automatic vec_t exc(input string name, input logic [31:0] pc, input logic bd,
                                input logic [4:0] code, input int wen_n);
      vec_t v = base(name, OP_EXC);
      v.pc = pc; v.bd = bd; v.exccode = code; v.redir_k = 4;
      v.redir_pc = 32'hBFC0_0380; v.wen_n = wen_n; v.busy_n = 4;
      return v;
   endfunction

   function automatic vec_t eret(input string name, input logic [31:0] target);
      vec_t v = base(name, OP_ERET);
      v.redir_k = 3; v.redir_pc = target; v.wen_n = 1; v.busy_n = 3;
      return v;
   endfunction

   // driver: present one request, drop valid after acceptance, observe 6 cycles
   task automatic run_vec(input vec_t v);
      int got_resp_k = 0, got_redir_k = 0, resp_n = 0, redir_n = 0, wen_n = 0, busy_n = 0;
      logic [31:0] got_resp_d = '0, got_redir_pc = '0;
      int both = 0, busy_bad = 0;
      @(negedge clk);
      check({v.name, " ready_before"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
      req_pc = v.pc; req_bd = v.bd; req_exccode = v.exccode;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) req_valid = 1'b0;
         if (resp_valid) begin
            resp_n++;
            if (got_resp_k == 0) begin got_resp_k = k; got_resp_d = resp_data; end
         end
         if (redirect_valid) begin
            redir_n++;
            if (got_redir_k == 0) begin got_redir_k = k; got_redir_pc = redirect_pc; end
         end
         if (resp_valid && redirect_valid) both++;
         if (cp0_wen) wen_n++;
         if (!req_ready) busy_n++;
         if (busy !== !req_ready) busy_bad++;
      end
      check({v.name, " resp_cycle"}, got_resp_k, v.resp_k);
      check({v.name, " resp_count"}, resp_n, (v.resp_k != 0) ? 1 : 0);
      if (v.resp_k != 0) check({v.name, " resp_data"}, got_resp_d, v.resp_d);
      check({v.name, " redir_cycle"}, got_redir_k, v.redir_k);
      check({v.name, " redir_count"}, redir_n, (v.redir_k != 0) ? 1 : 0);
      if (v.redir_k != 0) check({v.name, " redir_pc"}, got_redir_pc, v.redir_pc);
      check({v.name, " wen_cycles"}, wen_n, v.wen_n);
      check({v.name, " busy_cycles"}, busy_n, v.busy_n);
      check({v.name, " pulse_overlap"}, both, 0);
      check({v.name, " busy_vs_ready"}, busy_bad, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int resp_mask, ready_mask, redir_n, wen_n;

      vecs.push_back(mtc("mtc_64", 8'd64, 32'hDEAD_BEEF));
      vecs.push_back(mfc("mfc_64", 8'd64, 32'hDEAD_BEEF));
      vecs.push_back(base("nop", OP_NOP));
      vecs.push_back(base("op6_nop", 3'd6));
      vecs.push_back(mtc("st_clr", 8'd96, 32'h0));
      vecs.push_back(mtc("cause_clr", 8'd104, 32'h0));
      vecs.push_back(exc("exc1", 32'h8000_1000, 1'b0, 5'd4, 3));
      vecs.push_back(mfc("exc1_status", 8'd96, 32'h0000_0002));
      vecs.push_back(mfc("exc1_epc", 8'd112, 32'h8000_1000));
      vecs.push_back(mfc("exc1_cause", 8'd104, 32'h0000_0010));
      vecs.push_back(mtc("epc_1234", 8'd112, 32'h0000_1234));
      vecs.push_back(mtc("cause_300", 8'd104, 32'h0000_0300));
      vecs.push_back(exc("exc2_nested", 32'h0000_9000, 1'b1, 5'd8, 2));
      vecs.push_back(mfc("exc2_epc", 8'd112, 32'h0000_1234));
      vecs.push_back(mfc("exc2_cause", 8'd104, 32'h0000_0320));
      vecs.push_back(mfc("exc2_status", 8'd96, 32'h0000_0002));
      vecs.push_back(mtc("st_clr2", 8'd96, 32'h0));
      vecs.push_back(mtc("cause_7c", 8'd104, 32'h0000_007C));
      vecs.push_back(exc("exc3_wrap", 32'h0, 1'b1, 5'd0, 3));
      vecs.push_back(mfc("exc3_epc", 8'd112, 32'hFFFF_FFFC));
      vecs.push_back(mfc("exc3_cause", 8'd104, 32'h8000_0000));
      vecs.push_back(mtc("epc_2000", 8'd112, 32'h8000_2000));
      vecs.push_back(mtc("st_3", 8'd96, 32'h0000_0003));
      vecs.push_back(eret("eret", 32'h8000_2000));
      vecs.push_back(mfc("eret_status", 8'd96, 32'h0000_0001));

      repeat (3) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      check("rst_resp_data", resp_data, 32'd0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
      check("rst_cp0_wen", {31'd0, cp0_wen}, 32'd0);
      check("rst_cp0_addr", {24'd0, cp0_addr}, 32'd0);

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

      check("hold_redirect_pc", redirect_pc, 32'h8000_2000);
      check("hold_resp_data", resp_data, 32'h0000_0001);

      // valid held high across a whole MFC0: a second transfer only after IDLE
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_MFC0; req_addr = 8'd96;
      resp_mask = 0; ready_mask = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (resp_valid) resp_mask |= (1 << (k - 1));
         if (!req_ready) ready_mask |= (1 << (k - 1));
         if (k == 6) req_valid = 1'b0;
      end
      check("held_valid_resp_mask", resp_mask, 32'b010010);
      check("held_valid_busy_mask", ready_mask, 32'b011011);
      check("held_valid_data", resp_data, 32'h0000_0001);

      // reset landing in EX_EPC
      run_vec(mtc("rs_st", 8'd96, 32'h0));
      run_vec(mtc("rs_cause", 8'd104, 32'h0));
      run_vec(mtc("rs_epc", 8'd112, 32'h0000_5555));
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_EXC; req_pc = 32'h100; req_bd = 1'b0; req_exccode = 5'd3;
      @(negedge clk);
      check("rs_state_ex_st", {28'd0, dbg_state}, {28'd0, ST_EX_ST});
      @(negedge clk);
      check("rs_state_ex_epc", {28'd0, dbg_state}, {28'd0, ST_EX_EPC});
      resetn = 1'b0;
      @(negedge clk);
      check("rs_ready", {31'd0, req_ready}, 32'd1);
      check("rs_redirect", {31'd0, redirect_valid}, 32'd0);
      check("rs_wen", {31'd0, cp0_wen}, 32'd0);
      check("rs_redirect_pc", redirect_pc, 32'd0);
      check("rs_resp_data", resp_data, 32'd0);
      @(negedge clk);
      check("rs_held_idle", {28'd0, dbg_state}, {28'd0, ST_IDLE});
      resetn = 1'b1; req_valid = 1'b0;
      redir_n = 0; wen_n = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (redirect_valid) redir_n++;
         if (cp0_wen) wen_n++;
      end
      check("rs_no_redirect", redir_n, 0);
      check("rs_no_write", wen_n, 0);
      run_vec(mfc("rs_cause_kept", 8'd104, 32'h0));
      run_vec(mfc("rs_status_exl", 8'd96, 32'h0000_0002));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cp0_access_ctrl.md
Name: cp0_access_ctrl

Overview:
- Pipeline-side initiator for the CP0 register file; sits at the MEM stage boundary.
- Accepts one CP0 operation at a time (MFC0, MTC0, ERET, exception entry) over a valid/ready handshake.
- Sequences each operation as single-port accesses (one shared addr, one write enable, combinational read data) to the CP0 register file.
- Returns MFC0 read data, and for ERET and exceptions a PC redirect to fetch.

Parameters:
EXC_VECTOR, 32'hBFC0_0380, PC driven on redirect after exception entry
STATUS_ADDR, 8'd96, CP0 address of Status ({rd=12, sel=0})
CAUSE_ADDR, 8'd104, CP0 address of Cause ({rd=13, sel=0})
EPC_ADDR, 8'd112, CP0 address of EPC ({rd=14, sel=0})

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_op  in  3  0 NOP, 1 MFC0, 2 MTC0, 3 ERET, 4 EXC; 5-7 treated as NOP
req_addr  in  8  CP0 address {rd[4:0], sel[2:0]}; MFC0/MTC0 only
req_wdata  in  32  MTC0 write data
req_pc  in  32  PC of the faulting instruction (EXC)
req_bd  in  1  faulting instruction is in a delay slot (EXC)
req_exccode  in  5  exception code (EXC)
resp_valid  out  1  one-cycle pulse; resp_data valid
resp_data  out  32  MFC0 result
redirect_valid  out  1  one-cycle pulse; fetch must jump to redirect_pc
redirect_pc  out  32  redirect target
busy  out  1  operation in progress
cp0_wen  out  1  CP0 write enable
cp0_addr  out  8  CP0 address (read and write)
cp0_wdata  out  32  CP0 write data
cp0_rdata  in  32  CP0 read data, combinational from cp0_addr

Behaviour:
- Reset (synchronous, resetn=0 at a clk edge):
  - FSM goes to IDLE.
  - resp_valid=0, redirect_valid=0, resp_data=0, redirect_pc=0.
  - cp0_wen=0, busy=0.
  - Reset mid-sequence aborts the operation; no further CP0 writes, no pulses.
- Handshake:
  - req_ready = (state==IDLE).
  - A request is accepted on the clk edge where req_valid & req_ready; all req_* fields are latched at that edge.
  - busy = !req_ready.
- No combinational path from req_* to cp0_* or response outputs. cp0_* are decoded from the state and the latched fields only.
- cp0_wen=0 in every state not listed as writing below; cp0_addr=0 in IDLE.
- FSM states: IDLE, MFC, MTC, EX_ST, EX_EPC, EX_CAUSE, ER_EPC, ER_ST, FIN. T denotes the acceptance edge.
- NOP: accepted, stays in IDLE, no effect.
- MFC0:
  - T+1 MFC: cp0_addr=addr; resp_data <= cp0_rdata at the closing edge.
  - T+2 FIN: resp_valid=1; then IDLE.
- MTC0:
  - T+1 MTC: cp0_wen=1, cp0_addr=addr, cp0_wdata=wdata.
  - T+2 FIN: no pulse; then IDLE.
  - MFC0 of the same address issued afterwards returns the new value.
- EXC:
  - T+1 EX_ST: cp0_addr=STATUS_ADDR, cp0_wen=1, cp0_wdata=cp0_rdata|32'h2 (set EXL); old EXL latched.
  - T+2 EX_EPC: cp0_addr=EPC_ADDR. cp0_wen=!old_EXL. cp0_wdata = bd ? pc-4 : pc, 32-bit wrap (pc=0, bd=1 gives 32'hFFFF_FFFC).
  - T+3 EX_CAUSE: cp0_addr=CAUSE_ADDR, cp0_wen=1.
    - cp0_wdata = cp0_rdata with [6:2]=exccode.
    - [31]=bd if old_EXL==0, else [31] preserved.
    - All other bits preserved.
  - T+4 FIN: redirect_valid=1, redirect_pc=EXC_VECTOR; then IDLE.
- ERET:
  - T+1 ER_EPC: cp0_addr=EPC_ADDR; epc <= cp0_rdata.
  - T+2 ER_ST: cp0_addr=STATUS_ADDR, cp0_wen=1, cp0_wdata=cp0_rdata & ~32'h2.
  - T+3 FIN: redirect_valid=1, redirect_pc=epc; then IDLE.
- In FIN, req_ready=0. A new request is first accepted at the FIN->IDLE+1 edge.
- Pulses and outputs:
  - resp_valid and redirect_valid are never high in the same cycle; each lasts exactly one cycle.
  - resp_data and redirect_pc hold their last value until overwritten.

Decomposition:
- Shared package `cp0_pkg`:
  - op encoding constants (OP_NOP..OP_EXC);
  - CP0 address constants (Status/Cause/EPC);
  - bit positions (STATUS_EXL=1, CAUSE_BD=31, CAUSE_EXC=6:2);
  - FSM state enum;
  - exception vector default.
- Single module; no natural sub-module.

Test Plan:
- MTC0 addr=8'd64, wdata=32'hDEAD_BEEF; then MFC0 addr=8'd64 -> cp0_wen high exactly one cycle at T+1; resp_valid at T+2 of the MFC0, resp_data=32'hDEAD_BEEF.
- Status=0, EXC pc=32'h8000_1000, bd=0, exccode=5'd4 -> Status=32'h2, EPC=32'h8000_1000, Cause[6:2]=4, Cause[31]=0; redirect_valid at T+4 with 32'hBFC0_0380; req_ready low T+1..T+4.
- Status=32'h2 (EXL set), EPC=32'h1234, EXC pc=32'h9000, bd=1, exccode=5'd8 -> EPC stays 32'h1234, Cause[31] unchanged, Cause[6:2]=8, redirect to EXC_VECTOR.
- EXC pc=0, bd=1 with EXL=0 -> EPC=32'hFFFF_FFFC, Cause[31]=1.
- EPC=32'h8000_2000, Status=32'h3, ERET -> Status=32'h1, redirect_valid at T+3 with redirect_pc=32'h8000_2000.
- resetn=0 asserted during EX_EPC -> next cycle IDLE, req_ready=1, no redirect pulse, no Cause write; req_valid held high during busy is ignored until IDLE.
